kelvin_axi_rd_arbiter: RTL and testbench
========================================

Name: kelvin_axi_rd_arbiter

Overview:
- Shares one AXI4 read path (AR + R channels) of the testbench-facing DUT master port between two internal read requesters (src 0, src 1).
- AR channel: round-robin arbitration through a one-entry registered stage. The source index is prepended to ARID.
- R channel: beats are routed back by RID MSB.
- Per-source outstanding-burst limiting bounds in-flight reads.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 128, read data width
- IDWIDTH, 6, master-side ID width; source-side ID width is IDWIDTH-1
- MAX_OUT, 4, max outstanding bursts per source (>=1)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- sN_arvalid  in  1  (N=0,1) source read request valid
- sN_arready  out  1  (N=0,1) source request accepted
- sN_arid  in  IDWIDTH-1  (N=0,1) source ID
- sN_araddr  in  AWIDTH  (N=0,1) address
- sN_arlen  in  8  (N=0,1) burst length-1
- sN_arsize  in  3  (N=0,1) beat size
- sN_arburst  in  2  (N=0,1) burst type
- sN_rvalid  out  1  (N=0,1) routed read beat valid
- sN_rready  in  1  (N=0,1) source accepts beat
- sN_rid  out  IDWIDTH-1  (N=0,1) m_rid[IDWIDTH-2:0]
- sN_rdata  out  DWIDTH  (N=0,1) m_rdata
- sN_rresp  out  2  (N=0,1) m_rresp
- sN_rlast  out  1  (N=0,1) m_rlast
- m_arvalid  out  1  to master port
- m_arready  in  1
- m_arid  out  IDWIDTH  {src, sN_arid}
- m_araddr  out  AWIDTH
- m_arlen  out  8
- m_arsize  out  3
- m_arburst  out  2
- m_rvalid  in  1
- m_rready  out  1
- m_rid  in  IDWIDTH
- m_rdata  in  DWIDTH
- m_rresp  in  2
- m_rlast  in  1

Behaviour:
- Reset (async assert, sync release):
  - m_arvalid=0; all m_ar* payload registers 0.
  - cnt0=cnt1=0; rr_ptr=0 (src 0 has priority).
  - sN_arready=0 while resetn=0.
- Stage:
  - One-entry register holds m_ar*. m_arvalid=1 when full.
  - Stage "can load" when empty, or when m_arvalid&&m_arready this cycle.
  - Payload is stable while m_arvalid=1 and m_arready=0.
- Eligibility: source N is eligible when sN_arvalid=1 and cntN<MAX_OUT.
- Grant (combinational, each cycle when stage can load):
  - If both eligible, grant src rr_ptr.
  - Otherwise grant the single eligible source; no grant if none eligible.
  - sN_arready=1 only for the granted source.
  - Accept = sN_arvalid&&sN_arready.
- On accept of src N:
  - Load stage next edge: m_arid={N, sN_arid}, other fields copied.
  - rr_ptr <= ~N.
  - cntN increments.
- Latency and throughput:
  - Request to m_arvalid: 1 cycle.
  - Back-to-back accepts at 1/cycle when m_arready is held 1; both requesting gives alternation 0,1,0,1.
- R routing (combinational, zero latency):
  - sel=m_rid[IDWIDTH-1]; s{sel}_rvalid=m_rvalid; other source's rvalid=0.
  - m_rready=s{sel}_rready.
  - Data/resp/last/rid fanned out to both sources unconditionally.
- Counter decrement: cnt{sel} decrements on m_rvalid&&m_rready&&m_rlast.
- Simultaneous accept and last-beat on the same source: count unchanged.
- Counter width $clog2(MAX_OUT+1).
- Limit: cntN==MAX_OUT blocks src N only; the other source proceeds. Blocked src unblocks the cycle after its last beat completes.
- Error guard: last beat for a source with cnt==0 is a protocol error. Counter holds 0 and a simulation assertion fires.
- The arbiter never reorders or merges beats. Interleaving between sources follows the downstream RID order.
- Reset mid-operation:
  - Staged request and all outstanding tracking are discarded; m_arvalid drops immediately.
  - Downstream must be reset in the same domain.

Test Plan:
- Single src 0 request, addr 0x1000, arlen=3, id=5, m_arready=1 -> m_arvalid next cycle with m_arid=0x05; 4 R beats with rid=0x05 delivered on s0 only; cnt0 goes 1 then 0.
- Both sources valid every cycle, m_arready=1 -> m_arid MSB sequence 0,1,0,1...; one accept per cycle; no grant changes while m_arready=0.
- MAX_OUT=4, src 1 issues 4 bursts, no R returned -> s1_arready stays 0 on the 5th request while src 0 is still granted; one rlast to src 1 -> next-cycle grant resumes.
- m_arready held 0 for 3 cycles with m_arvalid=1 -> m_ar* payload unchanged; sN_arready=0 for both sources.
- Interleaved R beats rid=0x22 then 0x03 with s1_rready=0 -> m_rready=0 during the rid=0x22 beat; s0 receives nothing until that beat completes.
- resetn pulsed low with 2 outstanding and stage full -> m_arvalid=0 and sN_arready=0 immediately; after release cnt0=cnt1=0 and src 0 wins the first tie.

Source files
------------

// File: rtl/kelvin_axi_rd_arbiter.sv
// kelvin_axi_rd_arbiter
// Two internal read requesters share a single AXI4 read path (AR + R).
// AR requests are arbitrated round-robin into a one-entry registered stage,
// with the source index prepended to ARID. R beats are routed back by the
// RID MSB. Each source is limited to MAX_OUT bursts in flight; a source at
// its limit is blocked while the other source keeps going.

// Invariant checker: protocol and internal consistency checks, simulation only.
module kelvin_axi_rd_arbiter_chk #(
  parameter int CW      = 3,
  parameter int MAX_OUT = 4
) (
  input logic          clk,
  input logic          resetn,
  input logic [CW-1:0] cnt0,
  input logic [CW-1:0] cnt1,
  input logic          dec0,
  input logic          dec1,
  input logic          grant0,
  input logic          grant1
);

  // Check counters and grants once per cycle outside reset.
  always @(posedge clk) begin
    if (resetn) begin
      // A last beat for a source with nothing outstanding is a protocol error.
      assert (!(dec0 && (cnt0 == {CW{1'b0}})));
      assert (!(dec1 && (cnt1 == {CW{1'b0}})));
      // At most one source can win a given cycle.
      assert (!(grant0 && grant1));
      // The outstanding counters never exceed the configured limit.
      assert (int'(cnt0) <= MAX_OUT);
      assert (int'(cnt1) <= MAX_OUT);
    end
  end

endmodule

module kelvin_axi_rd_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 128,
  parameter int IDWIDTH = 6,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               resetn,

  // Source 0 AR channel
  input  logic               s0_arvalid,
  output logic               s0_arready,
  input  logic [IDWIDTH-2:0] s0_arid,
  input  logic [AWIDTH-1:0]  s0_araddr,
  input  logic [7:0]         s0_arlen,
  input  logic [2:0]         s0_arsize,
  input  logic [1:0]         s0_arburst,
  // Source 0 R channel
  output logic               s0_rvalid,
  input  logic               s0_rready,
  output logic [IDWIDTH-2:0] s0_rid,
  output logic [DWIDTH-1:0]  s0_rdata,
  output logic [1:0]         s0_rresp,
  output logic               s0_rlast,

  // Source 1 AR channel
  input  logic               s1_arvalid,
  output logic               s1_arready,
  input  logic [IDWIDTH-2:0] s1_arid,
  input  logic [AWIDTH-1:0]  s1_araddr,
  input  logic [7:0]         s1_arlen,
  input  logic [2:0]         s1_arsize,
  input  logic [1:0]         s1_arburst,
  // Source 1 R channel
  output logic               s1_rvalid,
  input  logic               s1_rready,
  output logic [IDWIDTH-2:0] s1_rid,
  output logic [DWIDTH-1:0]  s1_rdata,
  output logic [1:0]         s1_rresp,
  output logic               s1_rlast,

  // Master AR channel
  output logic               m_arvalid,
  input  logic               m_arready,
  output logic [IDWIDTH-1:0] m_arid,
  output logic [AWIDTH-1:0]  m_araddr,
  output logic [7:0]         m_arlen,
  output logic [2:0]         m_arsize,
  output logic [1:0]         m_arburst,
  // Master R channel
  input  logic               m_rvalid,
  output logic               m_rready,
  input  logic [IDWIDTH-1:0] m_rid,
  input  logic [DWIDTH-1:0]  m_rdata,
  input  logic [1:0]         m_rresp,
  input  logic               m_rlast
);

  // Counter must be able to hold the value MAX_OUT itself.
  localparam int            CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  // Saturating-at-zero up/down step for the outstanding-burst counters.
  // An increment and a decrement in the same cycle cancel out; a decrement
  // at zero (protocol error) leaves the counter at zero.
  function automatic logic [CW-1:0] cnt_next(
    input logic [CW-1:0] cnt,
    input logic          inc,
    input logic          dec
  );
    logic [CW-1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = cnt + CW'(1'b1);
      2'b01:   nxt = (cnt == {CW{1'b0}}) ? {CW{1'b0}} : cnt - CW'(1'b1);
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

  // Arbitration state
  logic          rr_ptr_r;   // source that wins the next tie
  logic [CW-1:0] cnt0_r;     // bursts accepted from src 0 and not yet finished
  logic [CW-1:0] cnt1_r;     // bursts accepted from src 1 and not yet finished

  // Combinational arbitration terms
  logic          can_load_s;
  logic          elig0_s;
  logic          elig1_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          acc0_s;
  logic          acc1_s;

  // R routing terms
  logic          r_sel_s;
  logic          r_last_hs_s;
  logic          dec0_s;
  logic          dec1_s;

  // Stage accepts a new request when empty or when it drains this cycle.
  always_comb begin
    can_load_s = 1'b0;
    if (!m_arvalid || m_arready) begin
      can_load_s = 1'b1;
    end else begin
      can_load_s = 1'b0;
    end
  end

  // A source is eligible while it requests and is below its in-flight limit.
  always_comb begin
    elig0_s = s0_arvalid && (cnt0_r < CNT_MAX);
    elig1_s = s1_arvalid && (cnt1_r < CNT_MAX);
  end

  // Round-robin grant: the pointer only matters when both sources compete.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (resetn && can_load_s) begin
      if (elig0_s && elig1_s) begin
        if (rr_ptr_r) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end else if (elig0_s) begin
        grant0_s = 1'b1;
      end else if (elig1_s) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Ready follows the grant directly so the source sees it in the same cycle.
  always_comb begin
    s0_arready = grant0_s;
    s1_arready = grant1_s;
    acc0_s     = s0_arvalid && grant0_s;
    acc1_s     = s1_arvalid && grant1_s;
  end

  // One-entry AR stage: load on accept, empty on handshake, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_arvalid <= 1'b0;
      m_arid    <= {IDWIDTH{1'b0}};
      m_araddr  <= {AWIDTH{1'b0}};
      m_arlen   <= 8'h00;
      m_arsize  <= 3'b000;
      m_arburst <= 2'b00;
    end else if (acc0_s) begin
      m_arvalid <= 1'b1;
      m_arid    <= {1'b0, s0_arid};
      m_araddr  <= s0_araddr;
      m_arlen   <= s0_arlen;
      m_arsize  <= s0_arsize;
      m_arburst <= s0_arburst;
    end else if (acc1_s) begin
      m_arvalid <= 1'b1;
      m_arid    <= {1'b1, s1_arid};
      m_araddr  <= s1_araddr;
      m_arlen   <= s1_arlen;
      m_arsize  <= s1_arsize;
      m_arburst <= s1_arburst;
    end else if (m_arready) begin
      // Drained (or already empty); payload is left as is, only valid drops.
      m_arvalid <= 1'b0;
    end else begin
      m_arvalid <= m_arvalid;
    end
  end

  // Round-robin pointer hands priority to the source that did not just win.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_r <= 1'b0;
    end else if (acc0_s) begin
      rr_ptr_r <= 1'b1;
    end else if (acc1_s) begin
      rr_ptr_r <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // R routing: the RID MSB names the source that owns the beat.
  always_comb begin
    r_sel_s   = m_rid[IDWIDTH-1];
    s0_rvalid = m_rvalid && !r_sel_s;
    s1_rvalid = m_rvalid && r_sel_s;
    if (r_sel_s) begin
      m_rready = s1_rready;
    end else begin
      m_rready = s0_rready;
    end
  end

  // Beat payload is fanned out to both sources; only rvalid is steered.
  always_comb begin
    s0_rid   = m_rid[IDWIDTH-2:0];
    s1_rid   = m_rid[IDWIDTH-2:0];
    s0_rdata = m_rdata;
    s1_rdata = m_rdata;
    s0_rresp = m_rresp;
    s1_rresp = m_rresp;
    s0_rlast = m_rlast;
    s1_rlast = m_rlast;
  end

  // A completed last beat retires one outstanding burst of its source.
  always_comb begin
    r_last_hs_s = m_rvalid && m_rready && m_rlast;
    dec0_s      = r_last_hs_s && !r_sel_s;
    dec1_s      = r_last_hs_s && r_sel_s;
  end

  // Outstanding-burst counters: +1 on accept, -1 on completed last beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt0_r <= {CW{1'b0}};
      cnt1_r <= {CW{1'b0}};
    end else begin
      cnt0_r <= cnt_next(cnt0_r, acc0_s, dec0_s);
      cnt1_r <= cnt_next(cnt1_r, acc1_s, dec1_s);
    end
  end

  kelvin_axi_rd_arbiter_chk #(
    .CW      (CW),
    .MAX_OUT (MAX_OUT)
  ) u_chk (
    .clk    (clk),
    .resetn (resetn),
    .cnt0   (cnt0_r),
    .cnt1   (cnt1_r),
    .dec0   (dec0_s),
    .dec1   (dec1_s),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

endmodule

// File: tb/tb_kelvin_axi_rd_arbiter.sv
// Testbench for kelvin_axi_rd_arbiter: directed scenarios followed by a
// randomized phase, all checked every cycle against a transaction-level
// model (pending-stage queue, in-flight burst list, per-source counts).
module tb_kelvin_axi_rd_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 128;
  localparam int IW      = 6;
  localparam int SW      = IW - 1;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          src_valid [2];
  logic [SW-1:0] src_id    [2];
  logic [AW-1:0] src_addr  [2];
  logic [7:0]    src_len   [2];
  logic [2:0]    src_size  [2];
  logic [1:0]    src_burst [2];
  logic          src_rready[2];

  logic          s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
  logic [SW-1:0] s0_rid, s1_rid;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp;
  logic          m_arvalid, m_rready;
  logic [IW-1:0] m_arid;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;

  logic          m_arready_i;
  logic          r_valid_i;
  logic [IW-1:0] r_id_i;
  logic [DW-1:0] r_data_i;
  logic [1:0]    r_resp_i;
  logic          r_last_i;

  kelvin_axi_rd_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .IDWIDTH(IW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s0_arvalid(src_valid[0]), .s0_arready(s0_arready), .s0_arid(src_id[0]),
    .s0_araddr(src_addr[0]), .s0_arlen(src_len[0]), .s0_arsize(src_size[0]),
    .s0_arburst(src_burst[0]),
    .s0_rvalid(s0_rvalid), .s0_rready(src_rready[0]), .s0_rid(s0_rid),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(src_valid[1]), .s1_arready(s1_arready), .s1_arid(src_id[1]),
    .s1_araddr(src_addr[1]), .s1_arlen(src_len[1]), .s1_arsize(src_size[1]),
    .s1_arburst(src_burst[1]),
    .s1_rvalid(s1_rvalid), .s1_rready(src_rready[1]), .s1_rid(s1_rid),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready_i), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(r_valid_i), .m_rready(m_rready), .m_rid(r_id_i),
    .m_rdata(r_data_i), .m_rresp(r_resp_i), .m_rlast(r_last_i)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  typedef struct {
    logic [IW-1:0] id;
    int            left;
  } burst_t;

  ar_t    stq[$];      // requests accepted but not yet handed to the master
  burst_t bursts[$];   // bursts issued on the master AR, beats still owed
  int     cnt[2];      // bursts in flight per source
  int     pri;         // source that wins the next tie
  int     r_cur;       // burst index of the beat currently presented
  int     n_cmp;
  int     n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ar_t req_of(input int n);
    ar_t r;
    r.id    = {n[0], src_id[n]};
    r.addr  = src_addr[n];
    r.len   = src_len[n];
    r.size  = src_size[n];
    r.burst = src_burst[n];
    return r;
  endfunction

  task automatic new_req(input int n, input logic [SW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len);
    src_valid[n] = 1'b1;
    src_id[n]    = id;
    src_addr[n]  = addr;
    src_len[n]   = len;
    src_size[n]  = 3'($urandom_range(0, 7));
    src_burst[n] = 2'($urandom_range(0, 2));
  endtask

  task automatic present_beat(input int idx);
    r_cur     = idx;
    r_valid_i = 1'b1;
    r_id_i    = bursts[idx].id;
    r_last_i  = (bursts[idx].left == 1);
    r_data_i  = {$urandom, $urandom, $urandom, $urandom};
    r_resp_i  = 2'($urandom_range(0, 3));
  endtask

  function automatic int find_burst(input logic [IW-1:0] id);
    for (int i = 0; i < bursts.size(); i++) begin
      if (bursts[i].id == id) return i;
    end
    return -1;
  endfunction

  function automatic int find_src(input int s);
    for (int i = 0; i < bursts.size(); i++) begin
      if (int'(bursts[i].id[IW-1]) == s) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    stq.delete();
    bursts.delete();
    cnt[0]    = 0;
    cnt[1]    = 0;
    pri       = 0;
    r_valid_i = 1'b0;
  endtask

  // Check one cycle against the model, then advance to posedge+1.
  task automatic tick();
    int g;
    bit cl, e0, e1, arhs, rhs, sel;
    #3;
    cl = (stq.size() == 0) || m_arready_i;
    e0 = src_valid[0] && (cnt[0] < MAX_OUT);
    e1 = src_valid[1] && (cnt[1] < MAX_OUT);
    g  = -1;
    if (cl) begin
      if (e0 && e1) g = pri;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
    end
    check("s0_arready", 128'(s0_arready), 128'(g == 0));
    check("s1_arready", 128'(s1_arready), 128'(g == 1));
    check("m_arvalid",  128'(m_arvalid),  128'(stq.size() != 0));
    if (stq.size() != 0) begin
      check("m_arid",    128'(m_arid),    128'(stq[0].id));
      check("m_araddr",  128'(m_araddr),  128'(stq[0].addr));
      check("m_arlen",   128'(m_arlen),   128'(stq[0].len));
      check("m_arsize",  128'(m_arsize),  128'(stq[0].size));
      check("m_arburst", 128'(m_arburst), 128'(stq[0].burst));
    end
    sel = r_id_i[IW-1];
    check("s0_rvalid", 128'(s0_rvalid), 128'(r_valid_i && !sel));
    check("s1_rvalid", 128'(s1_rvalid), 128'(r_valid_i && sel));
    check("m_rready",  128'(m_rready),  128'(src_rready[sel]));
    if (r_valid_i) begin
      check("s0_rdata", 128'(s0_rdata), 128'(r_data_i));
      check("s1_rdata", 128'(s1_rdata), 128'(r_data_i));
      check("s0_rid",   128'(s0_rid),   128'(r_id_i[SW-1:0]));
      check("s1_rid",   128'(s1_rid),   128'(r_id_i[SW-1:0]));
      check("s0_rresp", 128'(s0_rresp), 128'(r_resp_i));
      check("s1_rresp", 128'(s1_rresp), 128'(r_resp_i));
      check("s0_rlast", 128'(s0_rlast), 128'(r_last_i));
      check("s1_rlast", 128'(s1_rlast), 128'(r_last_i));
    end
    arhs = (stq.size() != 0) && m_arready_i;
    rhs  = r_valid_i && src_rready[sel];
    @(posedge clk);
    #1;
    if (arhs) begin
      bursts.push_back('{stq[0].id, int'(stq[0].len) + 1});
      void'(stq.pop_front());
    end
    if (g >= 0) begin
      stq.push_back(req_of(g));
      cnt[g]++;
      pri          = 1 - g;
      src_valid[g] = 1'b0;
    end
    if (rhs) begin
      bursts[r_cur].left = bursts[r_cur].left - 1;
      if (r_last_i) begin
        bursts.delete(r_cur);
        cnt[sel]--;
      end
      r_valid_i = 1'b0;
    end
  endtask

  task automatic rand_drive();
    for (int n = 0; n < 2; n++) begin
      if (!src_valid[n] && ($urandom_range(0, 1) == 1))
        new_req(n, SW'($urandom), $urandom, 8'($urandom_range(0, 3)));
      src_rready[n] = ($urandom_range(0, 3) != 0);
    end
    m_arready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic r_auto();
    if (!r_valid_i && (bursts.size() != 0) && ($urandom_range(0, 3) != 0))
      present_beat($urandom_range(0, bursts.size() - 1));
  endtask

  // Let pending requests finish and return all owed beats, bounded.
  task automatic drain();
    bit done;
    done          = 1'b0;
    m_arready_i   = 1'b1;
    src_rready[0] = 1'b1;
    src_rready[1] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ((stq.size() == 0) && (bursts.size() == 0) && !r_valid_i &&
          !src_valid[0] && !src_valid[1]) begin
        done = 1'b1;
        break;
      end
      r_auto();
      tick();
    end
    check("drain_done", 128'(done), 128'(1'b1));
  endtask

  initial begin
    ar_t hold;
    int  idx;
    n_cmp = 0;
    n_fail = 0;
    resetn = 1'b0;
    m_arready_i = 1'b0;
    r_id_i = '0; r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b0;
    for (int n = 0; n < 2; n++) begin
      src_valid[n] = 1'b1; src_id[n] = '0; src_addr[n] = '0; src_len[n] = 8'h00;
      src_size[n] = 3'b000; src_burst[n] = 2'b00; src_rready[n] = 1'b1;
    end
    model_reset();
    #12;
    // Reset state: stage empty and zeroed, no ready even with requests up.
    check("rst_m_arvalid", 128'(m_arvalid), 128'(1'b0));
    check("rst_m_arid",    128'(m_arid),    128'(6'h00));
    check("rst_m_araddr",  128'(m_araddr),  128'(32'h0));
    check("rst_s0_arready", 128'(s0_arready), 128'(1'b0));
    check("rst_s1_arready", 128'(s1_arready), 128'(1'b0));
    src_valid[0] = 1'b0;
    src_valid[1] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single src 0 burst of 4 beats.
    new_req(0, 5'h05, 32'h1000, 8'd3);
    m_arready_i = 1'b1;
    tick();
    check("t1_arvalid", 128'(m_arvalid), 128'(1'b1));
    check("t1_arid",    128'(m_arid),    128'(6'h05));
    check("t1_araddr",  128'(m_araddr),  128'(32'h1000));
    tick();
    for (int b = 0; b < 4; b++) begin
      present_beat(0);
      tick();
    end

    // Both sources every cycle: src 0 won last, so src 1 leads the alternation.
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < 2; n++)
        if (!src_valid[n]) new_req(n, SW'(i), 32'h2000 + 32'(i * 64 + n), 8'd0);
      tick();
      check("t2_alt", 128'(m_arid[IW-1]), 128'((i % 2) == 0));
    end

    // Stall: payload held, nobody granted.
    hold = stq[0];
    m_arready_i = 1'b0;
    for (int n = 0; n < 2; n++)
      if (!src_valid[n]) new_req(n, 5'h1f, 32'hdead0000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_arid_hold",   128'(m_arid),   128'(hold.id));
      check("t4_araddr_hold", 128'(m_araddr), 128'(hold.addr));
      check("t4_s0_arready",  128'(s0_arready), 128'(1'b0));
      check("t4_s1_arready",  128'(s1_arready), 128'(1'b0));
    end
    drain();

    // Outstanding limit on src 1.
    m_arready_i = 1'b1;
    for (int k = 0; k < MAX_OUT; k++) begin
      new_req(1, SW'(k), 32'h3000 + 32'(k * 64), 8'd0);
      tick();
    end
    new_req(1, 5'h0a, 32'h3400, 8'd0);
    new_req(0, 5'h0b, 32'h3800, 8'd0);
    tick();
    check("t3_s1_blocked", 128'(s1_arready), 128'(1'b0));
    idx = find_src(1);
    if (idx >= 0) present_beat(idx);
    tick();
    check("t3_s1_unblock", 128'(s1_arready), 128'(1'b1));
    drain();

    // R interleave: a stalled src 1 beat holds off the src 0 beat behind it.
    new_req(1, 5'h02, 32'h4000, 8'd0);
    new_req(0, 5'h03, 32'h4100, 8'd0);
    tick(); tick(); tick();
    src_rready[1] = 1'b0;
    src_rready[0] = 1'b1;
    idx = find_burst(6'h22);
    if (idx >= 0) present_beat(idx);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_m_rready",  128'(m_rready),  128'(1'b0));
      check("t5_s0_rvalid", 128'(s0_rvalid), 128'(1'b0));
    end
    src_rready[1] = 1'b1;
    tick();
    idx = find_burst(6'h03);
    if (idx >= 0) present_beat(idx);
    tick();
    drain();

    // Reset with two bursts outstanding and the stage full.
    new_req(0, 5'h06, 32'h5000, 8'd1);
    new_req(1, 5'h07, 32'h5100, 8'd1);
    tick(); tick();
    m_arready_i = 1'b0;
    new_req(0, 5'h08, 32'h5200, 8'd0);
    new_req(1, 5'h09, 32'h5300, 8'd0);
    tick();
    #1;
    resetn = 1'b0;
    #1;
    check("t6_m_arvalid",  128'(m_arvalid),  128'(1'b0));
    check("t6_s0_arready", 128'(s0_arready), 128'(1'b0));
    check("t6_s1_arready", 128'(s1_arready), 128'(1'b0));
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    m_arready_i = 1'b1;
    tick();
    check("t6_tie_src0", 128'(m_arid[IW-1]), 128'(1'b0));
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      r_auto();
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
